// File: rtl/cpu_out_uart.sv
// Captures CPU result values into a small FIFO and sends each one over UART
// as four uppercase hex characters followed by CR LF (8N1, LSB first).
module cpu_out_uart #(
  parameter int CLK_HZ      = 48000000,
  parameter int BAUD        = 115200,
  parameter int BAUD_DIV    = CLK_HZ / BAUD,
  parameter int DEPTH       = 4,
  parameter bit CHANGE_ONLY = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              data,
  input  logic                     valid,
  output logic                     tx,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [15:0]     last;
  logic            have_last;
  logic [15:0]     frame;
  logic [2:0]      char_idx;
  logic [2:0]      bit_idx;
  logic [CW-1:0]   baud_cnt;
  logic            pop;
  logic            push_req;
  logic            push_ok;
  logic            bit_end;
  logic [7:0]      cur_char;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign pop      = (state == IDLE) && (level != '0);
  assign push_req = valid && (!CHANGE_ONLY || !have_last || (data != last));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && ((level < FULL) || pop);
  assign bit_end  = (baud_cnt == BIT_LAST);
  assign busy     = (state != IDLE);

  always_comb begin
    cur_char = 8'h0A;
    case (char_idx)
      3'd0:    cur_char = hex_char(frame[15:12]);
      3'd1:    cur_char = hex_char(frame[11:8]);
      3'd2:    cur_char = hex_char(frame[7:4]);
      3'd3:    cur_char = hex_char(frame[3:0]);
      3'd4:    cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      last      <= '0;
      have_last <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr    <= wr_ptr + 1'b1;
        last      <= data;
        have_last <= 1'b1;
      end
      if (push_req && !push_ok) overflow <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      level <= level + 1'b1;
      else if (!push_ok && pop) level <= level - 1'b1;
    end
  end

  // tx is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      frame    <= '0;
      char_idx <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            frame    <= mem[rd_ptr];
            char_idx <= '0;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          tx <= cur_char[bit_idx];
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            if (char_idx == 3'd5) begin
              state <= IDLE;
            end else begin
              char_idx <= char_idx + 1'b1;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_out_uart.sv
// Self-checking bench: three cpu_out_uart instances (change-only / every-sample /
// slow baud) against a cycle-level behavioural model of queue and frame timing.
module tb_cpu_out_uart;

  localparam int BDV[3] = '{4, 4, 7};
  localparam int COV[3] = '{1, 0, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] data = 16'h0;
  logic        tx_w[3];
  logic        busy_w[3];
  logic        ovf_w[3];
  logic [2:0]  lvl_w[3];

  int checks = 0;
  int errors = 0;

  int          fc[3];
  logic [15:0] mq[3][4];
  int          mn[3];
  logic        hl[3];
  logic [15:0] lastv[3];
  logic        movf[3];
  logic [15:0] cur[3];
  logic        etx[3];
  int          frames[3];
  logic        bprev[3];

  logic        logging = 1'b0;
  int          log_n = 0;
  logic        tx_log[450];
  logic        busy_log[3][450];

  always #5 clk = ~clk;

  cpu_out_uart #(.BAUD_DIV(4), .DEPTH(4), .CHANGE_ONLY(1'b1)) u_a (
    .clk(clk), .rst(rst), .data(data), .valid(valid),
    .tx(tx_w[0]), .busy(busy_w[0]), .overflow(ovf_w[0]), .level(lvl_w[0]));
  cpu_out_uart #(.BAUD_DIV(4), .DEPTH(4), .CHANGE_ONLY(1'b0)) u_b (
    .clk(clk), .rst(rst), .data(data), .valid(valid),
    .tx(tx_w[1]), .busy(busy_w[1]), .overflow(ovf_w[1]), .level(lvl_w[1]));
  cpu_out_uart #(.BAUD_DIV(7), .DEPTH(4), .CHANGE_ONLY(1'b1)) u_c (
    .clk(clk), .rst(rst), .data(data), .valid(valid),
    .tx(tx_w[2]), .busy(busy_w[2]), .overflow(ovf_w[2]), .level(lvl_w[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] chr(input logic [15:0] v, input int c);
    int nib;
    if (c == 4) return 8'h0D;
    if (c == 5) return 8'h0A;
    nib = (int'(v) >> (12 - 4 * c)) & 15;
    if (nib < 10) return 8'(8'h30 + nib);
    return 8'(8'h41 + nib - 10);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      fc[d] = 0; mn[d] = 0; hl[d] = 1'b0; lastv[d] = '0;
      movf[d] = 1'b0; cur[d] = '0; etx[d] = 1'b1;
    end
  endtask

  // One clock edge of the reference: a frame is 60 bit periods of fixed-length
  // serial symbols; the line shows the symbol for the cycle before the edge.
  task automatic model_update();
    for (int d = 0; d < 3; d++) begin
      int pre_fc, pre_n, e, k, w;
      logic pop, req, acc;
      logic [7:0] ch;
      pre_fc = fc[d];
      pre_n  = mn[d];
      if (pre_fc > 0) begin
        e = 60 * BDV[d] - pre_fc;
        k = e / BDV[d];
        w = k % 10;
        ch = chr(cur[d], k / 10);
        if (w == 0)      etx[d] = 1'b0;
        else if (w == 9) etx[d] = 1'b1;
        else             etx[d] = ch[w-1];
        fc[d] = fc[d] - 1;
      end else begin
        etx[d] = 1'b1;
      end
      pop = (pre_fc == 0) && (pre_n > 0);
      req = valid && (COV[d] == 0 || !hl[d] || data != lastv[d]);
      acc = req && (pre_n < 4 || pop);
      if (req && !acc) movf[d] = 1'b1;
      if (acc) begin hl[d] = 1'b1; lastv[d] = data; end
      if (pop) begin
        cur[d] = mq[d][0];
        for (int i = 0; i < 3; i++) mq[d][i] = mq[d][i+1];
        mn[d] = mn[d] - 1;
        fc[d] = 60 * BDV[d];
      end
      if (acc) begin
        mq[d][mn[d]] = data;
        mn[d] = mn[d] + 1;
      end
    end
  endtask

  task automatic compare();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("tx[%0d]", d), int'(tx_w[d]), int'(etx[d]));
      chk($sformatf("busy[%0d]", d), int'(busy_w[d]), int'(fc[d] > 0));
      chk($sformatf("overflow[%0d]", d), int'(ovf_w[d]), int'(movf[d]));
      chk($sformatf("level[%0d]", d), int'(lvl_w[d]), mn[d]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_update();
    else model_reset();
    @(negedge clk);
    compare();
    for (int d = 0; d < 3; d++) begin
      if (busy_w[d] && !bprev[d]) frames[d]++;
      bprev[d] = busy_w[d];
    end
    if (logging && log_n < 450) begin
      tx_log[log_n] = tx_w[0];
      for (int d = 0; d < 3; d++) busy_log[d][log_n] = busy_w[d];
      log_n++;
    end
  endtask

  task automatic push(input logic [15:0] v);
    valid = 1'b1;
    data  = v;
    tick();
    valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((fc[0] > 0 || fc[1] > 0 || fc[2] > 0 || mn[0] > 0 || mn[1] > 0 || mn[2] > 0)
           && n < max) begin
      tick();
      n++;
    end
    chk("drain_within_bound", int'(n < max), 1);
    repeat (3) tick();
  endtask

  initial begin
    int f0[3];
    int idx, bc, low, n, e, k;
    logic [7:0] b;
    logic [7:0] exp_bytes[6];
    logic [15:0] pool[4];

    for (int d = 0; d < 3; d++) begin frames[d] = 0; bprev[d] = 1'b0; end
    model_reset();
    repeat (3) tick();
    chk("reset_tx", int'(tx_w[0]), 1);
    chk("reset_busy", int'(busy_w[0]), 0);
    chk("reset_overflow", int'(ovf_w[0]), 0);
    chk("reset_level", int'(lvl_w[0]), 0);
    rst = 1'b1;
    repeat (2) tick();

    // single value 1A2F: latency, decoded bytes, busy length
    exp_bytes = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    logging = 1'b1;
    log_n = 0;
    push(16'h1A2F);
    repeat (449) tick();
    logging = 1'b0;
    idx = -1;
    for (int i = 0; i < 450; i++) if (idx < 0 && !tx_log[i]) idx = i;
    chk("tx_fall_after_sample", idx, 2);
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 8; i++) b[i] = tx_log[2 + (c * 10 + 1 + i) * 4];
      chk($sformatf("byte%0d", c), int'(b), int'(exp_bytes[c]));
    end
    for (int d = 0; d < 3; d += 2) begin
      bc = 0;
      for (int i = 0; i < 450; i++) if (busy_log[d][i]) bc++;
      chk($sformatf("busy_cycles[%0d]", d), bc, d == 0 ? 240 : 420);
    end
    chk("after_frame_tx", int'(tx_w[0]), 1);
    chk("after_frame_level", int'(lvl_w[0]), 0);

    // change-only filter
    f0 = frames;
    push(16'h0005); repeat (2) tick();
    push(16'h0005); repeat (2) tick();
    push(16'h0005); repeat (2) tick();
    push(16'h0006);
    wait_idle(3000);
    chk("frames_change_only", frames[0] - f0[0], 2);
    chk("frames_every_sample", frames[1] - f0[1], 4);

    // overflow with consecutive pushes
    do_reset();
    f0 = frames;
    for (int v = 1; v <= 6; v++) push(16'(v));
    chk("ovf_level_full", int'(lvl_w[0]), 4);
    chk("ovf_set", int'(ovf_w[0]), 1);
    wait_idle(4000);
    chk("ovf_frames", frames[0] - f0[0], 5);
    chk("ovf_sticky", int'(ovf_w[0]), 1);

    // full FIFO plus push on the pop cycle
    do_reset();
    for (int v = 0; v < 5; v++) push(16'h0010 + 16'(v));
    chk("full_level", int'(lvl_w[0]), 4);
    n = 0;
    while (fc[0] != 0 && n < 400) begin tick(); n++; end
    chk("pop_cycle_found", int'(n < 400), 1);
    push(16'h0020);
    chk("simul_pop_level", int'(lvl_w[0]), 4);
    chk("simul_pop_no_ovf", int'(ovf_w[0]), 0);
    wait_idle(8000);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 4; i++) pool[i] = 16'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) push(pool[$urandom_range(0, 3)]);
      else tick();
    end
    wait_idle(8000);

    // reset during DATA of character 2
    do_reset();
    push(16'h1234);
    n = 0;
    e = 0; k = 0;
    while (n < 300) begin
      e = 240 - fc[0];
      k = e / 4;
      if (fc[0] > 0 && k >= 21 && k <= 27) break;
      tick();
      n++;
    end
    chk("mid_frame_reached", int'(n < 300), 1);
    rst = 1'b0;
    #1;
    chk("async_rst_tx", int'(tx_w[0]), 1);
    chk("async_rst_busy", int'(busy_w[0]), 0);
    chk("async_rst_level", int'(lvl_w[0]), 0);
    model_reset();
    tick();
    rst = 1'b1;
    low = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (!tx_w[0]) low++;
    end
    chk("idle_after_reset_low_cycles", low, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
